// File: rtl/mlp_key_pio_in.sv
// Debounced key/switch PIO input port with edge capture and level interrupt.
// Avalon-MM slave: 0 = debounced data, 1 = reserved, 2 = irq_mask,
// 3 = edge_capture (write-1-to-clear).
module mlp_key_pio_in #(
  parameter int unsigned DATA_WIDTH      = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned EDGE_TYPE       = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic                  irq
);

  // Counter only needs to hold DEBOUNCE_CYCLES-1; the next step reloads it.
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [DATA_WIDTH-1:0] sync1;
  logic [DATA_WIDTH-1:0] sync2;
  logic [DATA_WIDTH-1:0] deb;
  logic [DATA_WIDTH-1:0] deb_d;
  logic [CNT_W-1:0]      cnt [DATA_WIDTH];
  logic [DATA_WIDTH-1:0] irq_mask;
  logic [DATA_WIDTH-1:0] edge_capture;
  logic [DATA_WIDTH-1:0] edge_hit;
  logic [DATA_WIDTH-1:0] clr_bits;
  logic [31:0]           rd_next;
  logic                  wr;

  assign wr = chipselect & ~write_n;

  if (DATA_WIDTH < 32) begin : g_wd_unused
    logic unused_wdata;
    assign unused_wdata = ^writedata[31:DATA_WIDTH];
  end

  // Two-flop synchronizer on the raw pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

  // Per-bit debounce: accept a new level after DEBOUNCE_CYCLES consecutive differing cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb <= '0;
      for (int unsigned i = 0; i < DATA_WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Delayed copy of the debounced level for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) deb_d <= '0;
    else          deb_d <= deb;
  end

  // Edge filter selected by EDGE_TYPE.
  always_comb begin
    edge_hit = '0;
    if (EDGE_TYPE == 0)      edge_hit = deb & ~deb_d;
    else if (EDGE_TYPE == 1) edge_hit = ~deb & deb_d;
    else                     edge_hit = deb ^ deb_d;
  end

  // Write-1-to-clear mask for edge_capture.
  always_comb begin
    clr_bits = '0;
    if (wr && address == 2'd3) clr_bits = writedata[DATA_WIDTH-1:0];
  end

  // Register writes; a new edge is OR-ed in after the clear so set wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask     <= '0;
      edge_capture <= '0;
    end else begin
      if (wr && address == 2'd2) irq_mask <= writedata[DATA_WIDTH-1:0];
      edge_capture <= (edge_capture & ~clr_bits) | edge_hit;
    end
  end

  // Read mux, zero-extended.
  always_comb begin
    rd_next = '0;
    case (address)
      2'd0:    rd_next[DATA_WIDTH-1:0] = deb;
      2'd2:    rd_next[DATA_WIDTH-1:0] = irq_mask;
      2'd3:    rd_next[DATA_WIDTH-1:0] = edge_capture;
      default: rd_next = '0;
    endcase
  end

  // Registered read data, one-cycle latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_next;
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_mlp_key_pio_in.sv
// Bench for mlp_key_pio_in: directed table and sequences plus randomized
// traffic against a window-based reference model, on three edge flavours.
module tb_mlp_key_pio_in;

  localparam int DW = 10;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [DW-1:0] in_port;
  logic [31:0]   rd_rise, rd_fall, rd_any;
  logic          irq_rise, irq_fall, irq_any;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mlp_key_pio_in #(.DATA_WIDTH(DW), .DEBOUNCE_CYCLES(DB), .EDGE_TYPE(0)) u_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_rise),
    .in_port(in_port), .irq(irq_rise));

  mlp_key_pio_in #(.DATA_WIDTH(DW), .DEBOUNCE_CYCLES(DB), .EDGE_TYPE(1)) u_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_fall),
    .in_port(in_port), .irq(irq_fall));

  mlp_key_pio_in #(.DATA_WIDTH(DW), .DEBOUNCE_CYCLES(DB), .EDGE_TYPE(2)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_any),
    .in_port(in_port), .irq(irq_any));

  // Reference model: index 0 = rising, 1 = falling, 2 = any edge.
  logic [DW-1:0] m_deb, m_mask;
  logic [DW-1:0] m_ec   [3];
  logic [DW-1:0] m_pend [3];
  logic [31:0]   m_rd   [3];
  logic [DW-1:0] m_dly [$];
  logic [DW-1:0] m_win [$];

  task automatic model_reset();
    m_deb  = '0;
    m_mask = '0;
    for (int e = 0; e < 3; e++) begin
      m_ec[e] = '0; m_pend[e] = '0; m_rd[e] = '0;
    end
    m_dly.delete();
    m_win.delete();
  endtask

  // A level is accepted once the last DB synchronized samples all differ from it.
  task automatic model_step();
    logic [DW-1:0] y, all_diff, nxt, chg, clr;
    logic          wr;
    wr = chipselect && !write_n;
    for (int e = 0; e < 3; e++) begin
      case (address)
        2'd0:    m_rd[e] = 32'(m_deb);
        2'd2:    m_rd[e] = 32'(m_mask);
        2'd3:    m_rd[e] = 32'(m_ec[e]);
        default: m_rd[e] = 32'd0;
      endcase
    end
    y = (m_dly.size() >= 2) ? m_dly[0] : '0;
    m_dly.push_back(in_port);
    if (m_dly.size() > 2) void'(m_dly.pop_front());
    m_win.push_back(y);
    if (m_win.size() > DB) void'(m_win.pop_front());
    all_diff = '0;
    if (m_win.size() == DB) begin
      all_diff = '1;
      foreach (m_win[k]) all_diff &= (m_win[k] ^ m_deb);
    end
    nxt = m_deb ^ all_diff;
    chg = nxt ^ m_deb;
    clr = (wr && address == 2'd3) ? writedata[DW-1:0] : '0;
    for (int e = 0; e < 3; e++) m_ec[e] = (m_ec[e] & ~clr) | m_pend[e];
    m_pend[0] = chg & nxt;
    m_pend[1] = chg & ~nxt;
    m_pend[2] = chg;
    if (wr && address == 2'd2) m_mask = writedata[DW-1:0];
    m_deb = nxt;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Advance one clock: inputs were set at the falling edge, outputs sampled at the next one.
  task automatic tick();
    @(posedge clk);
    if (reset_n) model_step();
    @(negedge clk);
  endtask

  task automatic idle_read(input logic [1:0] a);
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = a;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    tick();
    write_n    = 1'b1;
  endtask

  typedef struct {
    logic        cs;
    logic        wn;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        irq;
  } bus_vec_t;

  bus_vec_t vt [12];

  initial begin
    int idx;

    // {cs, write_n, addr, writedata, expected readdata (pre-edge state), expected irq}
    vt[0]  = '{1'b1, 1'b0, 2'd2, 32'h0000_03FF, 32'h000, 1'b0};
    vt[1]  = '{1'b1, 1'b1, 2'd2, 32'h0000_0000, 32'h3FF, 1'b0};
    vt[2]  = '{1'b1, 1'b0, 2'd0, 32'hFFFF_FFFF, 32'h000, 1'b0};
    vt[3]  = '{1'b1, 1'b1, 2'd0, 32'h0000_0000, 32'h000, 1'b0};
    vt[4]  = '{1'b1, 1'b1, 2'd1, 32'h0000_0000, 32'h000, 1'b0};
    vt[5]  = '{1'b0, 1'b0, 2'd2, 32'h0000_0000, 32'h3FF, 1'b0};
    vt[6]  = '{1'b1, 1'b1, 2'd2, 32'h0000_0000, 32'h3FF, 1'b0};
    vt[7]  = '{1'b1, 1'b0, 2'd2, 32'hFFFF_FD55, 32'h3FF, 1'b0};
    vt[8]  = '{1'b1, 1'b1, 2'd2, 32'h0000_0000, 32'h155, 1'b0};
    vt[9]  = '{1'b1, 1'b0, 2'd1, 32'hFFFF_FFFF, 32'h000, 1'b0};
    vt[10] = '{1'b1, 1'b1, 2'd1, 32'h0000_0000, 32'h000, 1'b0};
    vt[11] = '{1'b1, 1'b1, 2'd3, 32'h0000_0000, 32'h000, 1'b0};

    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = '0;
    model_reset();
    repeat (3) tick();
    chk("reset_rd_fall", rd_fall, 32'h0);
    chk("reset_rd_rise", rd_rise, 32'h0);
    chk("reset_irq_fall", 32'(irq_fall), 32'h0);
    reset_n = 1'b1;

    // Register map access table.
    for (int i = 0; i < 12; i++) begin
      chipselect = vt[i].cs;
      write_n    = vt[i].wn;
      address    = vt[i].addr;
      writedata  = vt[i].wd;
      tick();
      chk($sformatf("tbl%0d_rd", i), rd_fall, vt[i].rd);
      chk($sformatf("tbl%0d_irq", i), 32'(irq_fall), 32'(vt[i].irq));
    end
    chipselect = 1'b0;
    write_n    = 1'b1;

    // Rising bit 0: data visible on readdata 7 edges after the change (6 + read latency).
    idle_read(2'd0);
    in_port[0] = 1'b1;
    repeat (6) tick();
    chk("deb_not_early", rd_fall, 32'h0);
    tick();
    chk("deb_bit0", rd_fall, 32'h001);
    chk("rise_irq", 32'(irq_rise), 32'h1);
    chk("fall_no_irq_on_rise", 32'(irq_fall), 32'h0);

    // 3-cycle glitch on bit 1 is rejected.
    in_port[1] = 1'b1;
    repeat (3) tick();
    in_port[1] = 1'b0;
    repeat (10) tick();
    chk("glitch_data", rd_fall, 32'h001);
    idle_read(2'd3);
    tick();
    chk("glitch_ec_fall", rd_fall, 32'h0);
    chk("glitch_ec_any", rd_any, 32'h001);
    chk("glitch_irq", 32'(irq_fall), 32'h0);

    // Falling edge on bit 2 with mask 0x004, then W1C.
    bus_write(2'd2, 32'h004);
    in_port[2] = 1'b1;
    repeat (8) tick();
    idle_read(2'd0);
    tick();
    chk("bit2_high_data", rd_fall, 32'h005);
    in_port[2] = 1'b0;
    repeat (6) tick();
    chk("fall_irq_not_early", 32'(irq_fall), 32'h0);
    tick();
    chk("fall_irq_set", 32'(irq_fall), 32'h1);
    idle_read(2'd3);
    tick();
    chk("fall_ec", rd_fall, 32'h004);
    bus_write(2'd3, 32'h004);
    chk("w1c_irq", 32'(irq_fall), 32'h0);
    tick();
    chk("w1c_ec", rd_fall, 32'h0);

    // Falling edge on bit 3 lands on the same edge as a W1C of bit 3: set wins.
    bus_write(2'd2, 32'h008);
    in_port[3] = 1'b1;
    repeat (8) tick();
    in_port[3] = 1'b0;
    repeat (6) tick();
    bus_write(2'd3, 32'h008);
    chk("setwin_irq", 32'(irq_fall), 32'h1);
    idle_read(2'd3);
    tick();
    chk("setwin_ec", rd_fall, 32'h008);
    bus_write(2'd3, 32'hFFFF_FFF7);
    chk("w1c_other_irq", 32'(irq_fall), 32'h1);
    idle_read(2'd3);
    tick();
    chk("w1c_other_ec", rd_fall, 32'h008);

    // Reset mid-count with mask/edge_capture set; bits 0 and 4 held high through release.
    idle_read(2'd0);
    in_port[4] = 1'b1;
    repeat (3) tick();
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("rst_async_irq", 32'(irq_fall), 32'h0);
    chk("rst_async_rd", rd_fall, 32'h0);
    chk("rst_async_rd_rise", rd_rise, 32'h0);
    @(negedge clk);
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (6) tick();
    chk("post_rst_not_early", rd_fall, 32'h0);
    tick();
    chk("post_rst_data", rd_fall, 32'h011);
    idle_read(2'd3);
    tick();
    chk("post_rst_ec_rise", rd_rise, 32'h011);
    chk("post_rst_ec_fall", rd_fall, 32'h0);
    chk("post_rst_irq", 32'(irq_rise), 32'h0);
    idle_read(2'd2);
    tick();
    chk("post_rst_mask", rd_fall, 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(5) == 0) begin
        idx = int'($urandom_range(DW - 1));
        in_port[idx] = ~in_port[idx];
      end
      chipselect = 1'($urandom_range(1));
      write_n    = ($urandom_range(3) != 0);
      address    = 2'($urandom_range(3));
      writedata  = $urandom & $urandom;
      tick();
      chk("rand_rd_rise", rd_rise, m_rd[0]);
      chk("rand_rd_fall", rd_fall, m_rd[1]);
      chk("rand_rd_any",  rd_any,  m_rd[2]);
      chk("rand_irq_rise", 32'(irq_rise), 32'(|(m_ec[0] & m_mask)));
      chk("rand_irq_fall", 32'(irq_fall), 32'(|(m_ec[1] & m_mask)));
      chk("rand_irq_any",  32'(irq_any),  32'(|(m_ec[2] & m_mask)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
